ec_point_op: RTL and testbench
==============================

EC_POINT_OP -- requirements
Module: ec_point_op

Interface
REQ-001 The module SHALL have parameter WIDTH, default 6: bit width of all coordinates, prime and curve coefficient a; legal range 3..16.
REQ-002 The module SHALL have parameter LAT_FIXED, default 0: when 1, out_valid is delayed to a constant latency of MAXLAT = 5*WIDTH+8 cycles; when 0, out_valid follows actual completion.
REQ-003 clk  input  1  single clock; all flops on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  one-cycle start strobe; operands are sampled on this edge.
REQ-006 in_Px, in_Py, in_Qx, in_Qy  input  WIDTH each  point coordinates, each < in_prime.
REQ-007 in_prime  input  WIDTH  odd prime modulus, >= 3.
REQ-008 in_a  input  WIDTH  curve coefficient a, < in_prime.
REQ-009 busy  output  1  high from the cycle after an accepted in_valid through the out_valid cycle.
REQ-010 out_valid  output  1  one-cycle result strobe.
REQ-011 out_Rx, out_Ry  output  WIDTH each  result R = P + Q; zero whenever out_valid is low.

Function
REQ-012 The block SHALL compute the operation on curve y^2 = x^3 + a*x + b (mod prime); b is not required as an input.
REQ-013 If P == Q, the block SHALL use lambda = (3*Px^2 + a) * inv(2*Py); otherwise it SHALL use lambda = (Qy - Py) * inv(Qx - Px).
REQ-014 The block SHALL compute Rx = lambda^2 - Px - Qx and Ry = lambda*(Px - Rx) - Py, all mod prime, with every result in 0..prime-1.
REQ-015 Point at infinity: if (Px == Qx and Py != Qy), or (P == Q and Py == 0), the block SHALL skip the inverse and output Rx = Ry = 0.
REQ-016 All intermediates SHALL be held at WIDTH+2 bits; modular multiplication SHALL be iterative shift-add with conditional subtract, WIDTH cycles per product.
REQ-017 The FSM SHALL have states IDLE, PREP (numerator and denominator), INV, MUL_L (lambda), MUL_X (lambda^2), MUL_Y, OUT.
- IDLE->PREP on in_valid.
- PREP->OUT directly on the infinity case.
- OUT->IDLE unconditionally.
REQ-018 Worst-case latency from the in_valid edge to out_valid SHALL be <= MAXLAT cycles; with LAT_FIXED=1 it SHALL be exactly MAXLAT.
REQ-019 An in_valid asserted while busy is high SHALL be ignored and SHALL NOT disturb the operation in flight.
REQ-020 in_valid in the same cycle as out_valid SHALL be ignored; a new operation may start from the following cycle.
REQ-021 out_valid SHALL be high for exactly one cycle per accepted operation.

Reset
REQ-022 While rst_n is low, the FSM SHALL be in IDLE and busy, out_valid, out_Rx, out_Ry and all datapath registers SHALL be 0.
REQ-023 A reset asserted mid-operation SHALL abort it with no out_valid for that operation; the first in_valid after release SHALL be accepted normally.

Configuration
REQ-024 With EC_INF_FLAG_EN defined, the block SHALL add output out_inf (1 bit), high together with out_valid exactly when REQ-015 applies, otherwise 0, and 0 at reset.
REQ-025 Without EC_INF_FLAG_EN, the port out_inf SHALL be absent; infinity SHALL be signalled only as (0,0).

Structure
REQ-026 Package ec_pkg SHALL hold the FSM state enum and the MAXLAT function of WIDTH.
REQ-027 Sub-module ec_mod_inv SHALL compute the modular inverse by iterative binary extended Euclid:
- start/done handshake;
- parametrised by WIDTH;
- <= 2*WIDTH+2 cycles.

Verification
REQ-028 Scenario 1 (point add): WIDTH=6, prime=17, a=2, P=(5,1), Q=(6,3) -> one out_valid pulse with R=(10,6).
REQ-029 Scenario 2 (doubling): WIDTH=6, prime=17, a=2, P=Q=(5,1) -> R=(6,3).
REQ-030 Scenario 3 (infinity, P = -Q): prime=17, P=(5,1), Q=(5,16) -> R=(0,0); out_inf=1 when EC_INF_FLAG_EN is defined.
REQ-031 Scenario 4 (infinity, doubling with Py=0): prime=7, a=1, P=Q=(3,0) -> R=(0,0).
REQ-032 Scenario 5 (wider WIDTH):
- WIDTH=8, prime=97, a=2, P=Q=(3,6) -> R=(80,10);
- then P=(80,10), Q=(3,6) -> R=(80,87);
- with LAT_FIXED=1, both latencies equal 48.
REQ-033 Scenario 6 (reset and busy):
- rst_n pulsed low 5 cycles after in_valid -> no out_valid, outputs 0;
- a second in_valid while busy -> ignored;
- a new operation after release -> correct result.

Source files
------------

// File: rtl/ec_pkg.sv
// Shared definitions for the EC point add/double engine: FSM states and
// the worst-case latency as a function of coordinate width.
package ec_pkg;
  typedef enum logic [2:0] {IDLE, PREP, INV, MUL_L, MUL_X, MUL_Y, OUT} ec_state_t;

  function automatic int ec_max_lat(input int width);
    return 5 * width + 8;
  endfunction
endpackage

// File: rtl/ec_mod_inv.sv
// Modular inverse by binary extended Euclid. One halving (or subtract+halve)
// per cycle, so at most 2*WIDTH-2 steps; done pulses one cycle, inv is held.
module ec_mod_inv #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH+1:0] den,
  input  logic [WIDTH+1:0] prime,
  output logic             done,
  output logic [WIDTH+1:0] inv
);
  typedef logic [WIDTH+1:0] xw_t;
  localparam xw_t ONE = xw_t'(1);

  xw_t  u, v, x1, x2, p;
  logic run;

  function automatic xw_t half(xw_t x, xw_t m);
    return x[0] ? (x + m) >> 1 : x >> 1;
  endfunction

  function automatic xw_t msub(xw_t x, xw_t y, xw_t m);
    return (x >= y) ? x - y : x + m - y;
  endfunction

  // Invariant: x1*den == u and x2*den == v (mod p).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u <= '0; v <= '0; x1 <= '0; x2 <= '0; p <= '0;
      run <= 1'b0; done <= 1'b0; inv <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        u <= den; v <= prime; x1 <= ONE; x2 <= '0; p <= prime;
        run <= 1'b1;
      end else if (run) begin
        if (u == ONE) begin
          inv <= x1; done <= 1'b1; run <= 1'b0;
        end else if (v == ONE) begin
          inv <= x2; done <= 1'b1; run <= 1'b0;
        end else if (!u[0]) begin
          u <= u >> 1; x1 <= half(x1, p);
        end else if (!v[0]) begin
          v <= v >> 1; x2 <= half(x2, p);
        end else if (u >= v) begin
          u <= (u - v) >> 1; x1 <= half(msub(x1, x2, p), p);
        end else begin
          v <= (v - u) >> 1; x2 <= half(msub(x2, x1, p), p);
        end
      end
    end
  end
endmodule

// File: rtl/ec_point_op.sv
// Elliptic-curve point add/double R = P + Q over GF(prime), iterative datapath.
// Optional out_inf flag enabled by defining EC_INF_FLAG_EN.
module ec_point_op
  import ec_pkg::*;
#(
  parameter int WIDTH     = 6,
  parameter int LAT_FIXED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_Px,
  input  logic [WIDTH-1:0] in_Py,
  input  logic [WIDTH-1:0] in_Qx,
  input  logic [WIDTH-1:0] in_Qy,
  input  logic [WIDTH-1:0] in_prime,
  input  logic [WIDTH-1:0] in_a,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_Rx,
  output logic [WIDTH-1:0] out_Ry
`ifdef EC_INF_FLAG_EN
  ,
  output logic             out_inf
`endif
);
  typedef logic [WIDTH+1:0] xw_t;
  typedef logic [WIDTH-1:0] w_t;
  localparam logic [4:0] CNT_LAST = 5'(WIDTH - 1);
  localparam logic [7:0] REL_CNT  = 8'(ec_max_lat(WIDTH) - 1);

  ec_state_t  state;
  xw_t        px, py, qx, qy, p, a, num, lam, rx, res_x, res_y;
  xw_t        acc, m_a, m_b;
  logic [4:0] cnt;
  logic [7:0] lat_cnt;
  logic       inv_rdy, inv_done;
  xw_t        inv_val;
`ifdef EC_INF_FLAG_EN
  logic       res_inf;
`endif

  function automatic xw_t mod_add(xw_t x, xw_t y, xw_t m);
    xw_t s;
    s = x + y;
    return (s >= m) ? s - m : s;
  endfunction

  function automatic xw_t mod_sub(xw_t x, xw_t y, xw_t m);
    return (x >= y) ? x - y : x + m - y;
  endfunction

  // MSB-first shift-add: acc = 2*acc + bit*mult, reduced after each half-step.
  function automatic xw_t mul_step(xw_t acc_in, xw_t mult, logic b, xw_t m);
    xw_t t;
    t = acc_in << 1;
    if (t >= m) t = t - m;
    if (b) t = t + mult;
    if (t >= m) t = t - m;
    return t;
  endfunction

  xw_t  acc_nx, den, num_nx, rx_nx, ry_nx;
  logic same, inf, last, mul_run, inv_start;

  assign acc_nx    = mul_step(acc, m_a, m_b[WIDTH-1], p);
  assign same      = (px == qx) && (py == qy);
  assign inf       = (px == qx) && ((py != qy) || (py == '0));
  assign last      = (cnt == CNT_LAST);
  assign den       = same ? mod_add(py, py, p) : mod_sub(qx, px, p);
  // In PREP the multiplier squares Px while the inverse of the denominator runs.
  assign num_nx    = same ? mod_add(mod_add(mod_add(acc_nx, acc_nx, p), acc_nx, p), a, p)
                          : mod_sub(qy, py, p);
  assign rx_nx     = mod_sub(mod_sub(acc_nx, px, p), qx, p);
  assign ry_nx     = mod_sub(acc_nx, py, p);
  assign mul_run   = ((state == PREP) && !inf) || (state == MUL_L) ||
                     (state == MUL_X) || (state == MUL_Y);
  assign inv_start = (state == PREP) && (cnt == '0) && !inf;

  ec_mod_inv #(.WIDTH(WIDTH)) u_inv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (inv_start),
    .den   (den),
    .prime (p),
    .done  (inv_done),
    .inv   (inv_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE; busy <= 1'b0; out_valid <= 1'b0;
      out_Rx <= '0; out_Ry <= '0;
      px <= '0; py <= '0; qx <= '0; qy <= '0; p <= '0; a <= '0;
      num <= '0; lam <= '0; rx <= '0; res_x <= '0; res_y <= '0;
      acc <= '0; m_a <= '0; m_b <= '0; cnt <= '0; lat_cnt <= '0;
      inv_rdy <= 1'b0;
`ifdef EC_INF_FLAG_EN
      res_inf <= 1'b0; out_inf <= 1'b0;
`endif
    end else begin
      if (busy) lat_cnt <= lat_cnt + 8'd1;
      if (inv_done) inv_rdy <= 1'b1;
      if (mul_run) begin
        acc <= acc_nx; m_b <= m_b << 1; cnt <= cnt + 5'd1;
      end
      case (state)
        IDLE: if (in_valid) begin
          px <= xw_t'(in_Px); py <= xw_t'(in_Py);
          qx <= xw_t'(in_Qx); qy <= xw_t'(in_Qy);
          p  <= xw_t'(in_prime); a <= xw_t'(in_a);
          m_a <= xw_t'(in_Px); m_b <= xw_t'(in_Px); acc <= '0; cnt <= '0;
          busy <= 1'b1; lat_cnt <= '0; inv_rdy <= 1'b0;
`ifdef EC_INF_FLAG_EN
          res_inf <= 1'b0;
`endif
          state <= PREP;
        end
        PREP: if (inf) begin
          res_x <= '0; res_y <= '0;
`ifdef EC_INF_FLAG_EN
          res_inf <= 1'b1;
`endif
          state <= OUT;
        end else if (last) begin
          num <= num_nx; state <= INV;
        end
        INV: if (inv_rdy || inv_done) begin
          m_a <= num; m_b <= inv_val; acc <= '0; cnt <= '0;
          state <= MUL_L;
        end
        MUL_L: if (last) begin
          lam <= acc_nx; m_a <= acc_nx; m_b <= acc_nx; acc <= '0; cnt <= '0;
          state <= MUL_X;
        end
        MUL_X: if (last) begin
          rx <= rx_nx; m_a <= lam; m_b <= mod_sub(px, rx_nx, p);
          acc <= '0; cnt <= '0;
          state <= MUL_Y;
        end
        MUL_Y: if (last) begin
          res_x <= rx; res_y <= ry_nx; state <= OUT;
        end
        OUT: begin
          // OUT holds until release; the out_valid cycle itself stays busy.
          if (out_valid) begin
            out_valid <= 1'b0; out_Rx <= '0; out_Ry <= '0; busy <= 1'b0;
`ifdef EC_INF_FLAG_EN
            out_inf <= 1'b0;
`endif
            state <= IDLE;
          end else if (LAT_FIXED == 0 || lat_cnt == REL_CNT) begin
            out_valid <= 1'b1; out_Rx <= w_t'(res_x); out_Ry <= w_t'(res_y);
`ifdef EC_INF_FLAG_EN
            out_inf <= res_inf;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ec_point_op.sv
// Bench for ec_point_op: scenario table, reset/busy sequences and random
// operations checked against a plain-arithmetic curve model.
module tb_ec_point_op;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic v6 = 1'b0, busy6, ov6;
  logic [5:0] p6 = '0, a6 = '0, px6 = '0, py6 = '0, qx6 = '0, qy6 = '0, rx6, ry6;
  logic v8 = 1'b0, busy8, ov8;
  logic [7:0] p8 = '0, a8 = '0, px8 = '0, py8 = '0, qx8 = '0, qy8 = '0, rx8, ry8;
`ifdef EC_INF_FLAG_EN
  logic inf6, inf8;
`endif

  ec_point_op #(.WIDTH(6), .LAT_FIXED(0)) d6 (
    .clk(clk), .rst_n(rst_n), .in_valid(v6), .in_Px(px6), .in_Py(py6),
    .in_Qx(qx6), .in_Qy(qy6), .in_prime(p6), .in_a(a6), .busy(busy6),
    .out_valid(ov6), .out_Rx(rx6), .out_Ry(ry6)
`ifdef EC_INF_FLAG_EN
    , .out_inf(inf6)
`endif
  );

  ec_point_op #(.WIDTH(8), .LAT_FIXED(1)) d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_Px(px8), .in_Py(py8),
    .in_Qx(qx8), .in_Qy(qy8), .in_prime(p8), .in_a(a8), .busy(busy8),
    .out_valid(ov8), .out_Rx(rx8), .out_Ry(ry8)
`ifdef EC_INF_FLAG_EN
    , .out_inf(inf8)
`endif
  );

  int n_chk = 0, n_fail = 0;
  int pr6[17] = '{3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53, 59, 61};
  int pr8[10] = '{67, 71, 97, 101, 127, 131, 193, 211, 241, 251};

  typedef struct {
    bit wide; int p, a, px, py, qx, qy, ex, ey; bit einf; int poke;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int md(input int x, input int p);
    int r;
    r = x % p;
    return (r < 0) ? r + p : r;
  endfunction

  function automatic int minv(input int x, input int p);
    for (int i = 1; i < p; i++) if (md(x * i, p) == 1) return i;
    return 0;
  endfunction

  function automatic void model(input int p, a, px, py, qx, qy,
                                output int rx, output int ry, output bit inf);
    int lam;
    if (px == qx && (py != qy || py == 0)) begin
      rx = 0; ry = 0; inf = 1'b1; return;
    end
    inf = 1'b0;
    if (px == qx) lam = md((3 * px * px + a) * minv(md(2 * py, p), p), p);
    else          lam = md(md(qy - py, p) * minv(md(qx - px, p), p), p);
    rx = md(lam * lam - px - qx, p);
    ry = md(lam * (px - rx) - py, p);
  endfunction

  task automatic drive(input bit wide, input int p, a, px, py, qx, qy);
    if (wide) begin
      p8 = 8'(p); a8 = 8'(a); px8 = 8'(px); py8 = 8'(py); qx8 = 8'(qx); qy8 = 8'(qy); v8 = 1'b1;
    end else begin
      p6 = 6'(p); a6 = 6'(a); px6 = 6'(px); py6 = 6'(py); qx6 = 6'(qx); qy6 = 6'(qy); v6 = 1'b1;
    end
  endtask

  // poke > 0: extra in_valid at that cycle; poke < 0: extra in_valid on the out_valid cycle.
  task automatic run_op(input bit wide, input int p, a, px, py, qx, qy, ex, ey,
                        input bit einf, input int poke, input string tag);
    int lim, lat, pulses, nz, grx, gry, gbusy, ginf, ov, orx, ory;
    lim = wide ? 52 : 42;
    lat = -1; pulses = 0; nz = 0; grx = -1; gry = -1; gbusy = 0; ginf = -1;
    @(negedge clk);
    drive(wide, p, a, px, py, qx, qy);
    @(posedge clk); #1;
    v6 = 1'b0; v8 = 1'b0;
    for (int c = 1; c <= lim; c++) begin
      @(posedge clk); #1;
      v6 = 1'b0; v8 = 1'b0;
      ov  = wide ? int'(ov8) : int'(ov6);
      orx = wide ? int'(rx8) : int'(rx6);
      ory = wide ? int'(ry8) : int'(ry6);
      if (ov != 0) begin
        pulses++;
        if (pulses == 1) begin
          lat = c; grx = orx; gry = ory; gbusy = wide ? int'(busy8) : int'(busy6);
`ifdef EC_INF_FLAG_EN
          ginf = wide ? int'(inf8) : int'(inf6);
`endif
        end
      end else if (orx != 0 || ory != 0) nz++;
      if (c == poke || (poke < 0 && ov != 0 && pulses == 1))
        drive(wide, p, a, px, py, px, (py + 1) % p);
    end
    v6 = 1'b0; v8 = 1'b0;
    chk({tag, "_rx"}, grx, ex);
    chk({tag, "_ry"}, gry, ey);
    chk({tag, "_pulses"}, pulses, 1);
    if (wide) chk({tag, "_lat_exact"}, lat, 48);
    else      chk({tag, "_lat_bound"}, int'(lat >= 1 && lat <= 38), 1);
    chk({tag, "_busy_at_out"}, gbusy, 1);
    chk({tag, "_busy_end"}, wide ? int'(busy8) : int'(busy6), 0);
    chk({tag, "_zero_idle"}, nz, 0);
`ifdef EC_INF_FLAG_EN
    chk({tag, "_inf"}, ginf, int'(einf));
`else
    if (einf) chk({tag, "_inf_as_zero"}, grx + gry, 0);
`endif
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int pulses, p, a, px, py, qx, qy, ex, ey, k;
    bit wide, einf;
    tbl[0] = '{1'b0, 17, 2, 5, 1, 6, 3, 10, 6, 1'b0, 0};
    tbl[1] = '{1'b0, 17, 2, 5, 1, 5, 1, 6, 3, 1'b0, 0};
    tbl[2] = '{1'b0, 17, 2, 5, 1, 5, 16, 0, 0, 1'b1, 0};
    tbl[3] = '{1'b0, 7, 1, 3, 0, 3, 0, 0, 0, 1'b1, 0};
    tbl[4] = '{1'b1, 97, 2, 3, 6, 3, 6, 80, 10, 1'b0, 0};
    tbl[5] = '{1'b1, 97, 2, 80, 10, 3, 6, 80, 87, 1'b0, 0};
    tbl[6] = '{1'b0, 17, 2, 5, 1, 6, 3, 10, 6, 1'b0, 3};
    tbl[7] = '{1'b0, 17, 2, 5, 1, 5, 1, 6, 3, 1'b0, -1};
    tbl[8] = '{1'b1, 97, 2, 3, 6, 3, 91, 0, 0, 1'b1, 0};

    #1;
    chk("rst_ov6", int'(ov6), 0);   chk("rst_busy6", int'(busy6), 0);
    chk("rst_rx6", int'(rx6), 0);   chk("rst_ry6", int'(ry6), 0);
    chk("rst_ov8", int'(ov8), 0);   chk("rst_busy8", int'(busy8), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i])
      run_op(tbl[i].wide, tbl[i].p, tbl[i].a, tbl[i].px, tbl[i].py, tbl[i].qx, tbl[i].qy,
             tbl[i].ex, tbl[i].ey, tbl[i].einf, tbl[i].poke, $sformatf("vec%0d", i));

    // Reset mid-operation must abort silently.
    @(negedge clk);
    drive(1'b0, 17, 2, 5, 1, 6, 3);
    @(posedge clk); #1 v6 = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_rst_ov", int'(ov6), 0);
    chk("abort_rst_busy", int'(busy6), 0);
    chk("abort_rst_rx", int'(rx6), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); #1;
      if (ov6) pulses++;
    end
    chk("abort_no_out", pulses, 0);
    chk("abort_idle_busy", int'(busy6), 0);
    run_op(1'b0, 17, 2, 5, 1, 6, 3, 10, 6, 1'b0, 0, "after_rst");

    for (int i = 0; i < 48; i++) begin
      wide = (i % 3 == 2);
      p  = wide ? pr8[$urandom_range(0, 9)] : pr6[$urandom_range(0, 16)];
      a  = $urandom_range(0, p - 1);
      px = $urandom_range(0, p - 1);
      py = $urandom_range(0, p - 1);
      k  = $urandom_range(0, 3);
      if (k == 0) begin
        if ($urandom_range(0, 3) == 0) py = 0;
        qx = px; qy = py;
      end else if (k == 1) begin
        qx = px; qy = $urandom_range(0, p - 1);
      end else begin
        qx = $urandom_range(0, p - 1); qy = $urandom_range(0, p - 1);
      end
      model(p, a, px, py, qx, qy, ex, ey, einf);
      run_op(wide, p, a, px, py, qx, qy, ex, ey, einf, 0, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
